// File: rtl/exe_hazard_sched.sv
// exe_hazard_sched: EXE-stage pipeline scheduler for the 5-stage MIPS core.
// It decides each cycle whether IF/ID advance, stall or flush, and whether
// a bubble enters EXE. It sequences multi-cycle mult/div ops by holding EXE
// for MD_LAT cycles, and it produces registered operand-forwarding selects.
// Build option: define EXE_HS_FWD_EN to enable operand forwarding. Without
// it, every EXE/MEM data hazard stalls, and the forwarding selects stay 00.
module exe_hazard_sched #(
  parameter int MD_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_HS_idRs,
  input  logic [4:0] i_HS_idRt,
  input  logic       i_HS_idUseRs,
  input  logic       i_HS_idUseRt,
  input  logic       i_HS_exeRegWe,
  input  logic       i_HS_exeLoad,
  input  logic [4:0] i_HS_exeWRA,
  input  logic       i_HS_memRegWe,
  input  logic [4:0] i_HS_memWRA,
  input  logic       i_HS_exeMd,
  input  logic       i_HS_exeClr,
  output logic       o_HS_stall,
  output logic       o_HS_flushID,
  output logic       o_HS_bubbleEXE,
  output logic       o_HS_holdEXE,
  output logic       o_HS_bubbleMEM,
  output logic [1:0] o_HS_fwdA,
  output logic [1:0] o_HS_fwdB,
  output logic       o_HS_mdBusy
);

  typedef enum logic {RUN, MDWAIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hz_exe_rs, hz_exe_rt, hz_mem_rs, hz_mem_rt;
  logic       hz_exe, hz_mem, data_stall;

  // Source/destination matches; register 0 never counts as a hazard
  always_comb begin
    hz_exe_rs = i_HS_idUseRs && (i_HS_idRs != 5'd0) && i_HS_exeRegWe && (i_HS_idRs == i_HS_exeWRA);
    hz_exe_rt = i_HS_idUseRt && (i_HS_idRt != 5'd0) && i_HS_exeRegWe && (i_HS_idRt == i_HS_exeWRA);
    hz_mem_rs = i_HS_idUseRs && (i_HS_idRs != 5'd0) && i_HS_memRegWe && (i_HS_idRs == i_HS_memWRA);
    hz_mem_rt = i_HS_idUseRt && (i_HS_idRt != 5'd0) && i_HS_memRegWe && (i_HS_idRt == i_HS_memWRA);
    hz_exe    = hz_exe_rs || hz_exe_rt;
    hz_mem    = hz_mem_rs || hz_mem_rt;
  end

`ifdef EXE_HS_FWD_EN
  // With forwarding only a load result arrives too late for the next op
  assign data_stall = i_HS_exeLoad && hz_exe;
`else
  // Without forwarding any pending write to a source stalls; a load is one case of it
  assign data_stall = hz_exe || hz_mem || (i_HS_exeLoad && hz_exe);
`endif

  // Next-state and pipeline control; everything stays low while in reset
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    o_HS_stall     = 1'b0;
    o_HS_flushID   = 1'b0;
    o_HS_bubbleEXE = 1'b0;
    o_HS_holdEXE   = 1'b0;
    o_HS_bubbleMEM = 1'b0;
    o_HS_mdBusy    = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          if (i_HS_exeClr) begin
            o_HS_flushID   = 1'b1;
            o_HS_bubbleEXE = 1'b1;
          end else if (i_HS_exeMd) begin
            o_HS_stall     = 1'b1;
            o_HS_holdEXE   = 1'b1;
            o_HS_bubbleMEM = 1'b1;
            o_HS_mdBusy    = 1'b1;
            state_d        = MDWAIT;
            cnt_d          = 8'(MD_LAT - 2);
          end else if (data_stall) begin
            o_HS_stall     = 1'b1;
            o_HS_bubbleEXE = 1'b1;
          end
        end
        MDWAIT: begin
          o_HS_stall     = 1'b1;
          o_HS_holdEXE   = 1'b1;
          o_HS_bubbleMEM = 1'b1;
          o_HS_mdBusy    = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and md latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef EXE_HS_FWD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d, sel_a, sel_b;

  // Forward selects follow the ID op into EXE; a bubble clears them, a hold keeps them
  always_comb begin
    sel_a   = hz_exe_rs ? 2'b01 : (hz_mem_rs ? 2'b10 : 2'b00);
    sel_b   = hz_exe_rt ? 2'b01 : (hz_mem_rt ? 2'b10 : 2'b00);
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (o_HS_bubbleEXE) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else if (!o_HS_holdEXE) begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
    end
  end

  // Forward select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign o_HS_fwdA = rst ? 2'b00 : fwd_a_q;
  assign o_HS_fwdB = rst ? 2'b00 : fwd_b_q;
`else
  assign o_HS_fwdA = 2'b00;
  assign o_HS_fwdB = 2'b00;
`endif

endmodule

// File: tb/tb_exe_hazard_sched.sv
// Testbench for exe_hazard_sched: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduler.
// Follows the EXE_HS_FWD_EN build option of the design.
module tb_exe_hazard_sched;

  localparam int MD_LAT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, exe_wra, mem_wra;
  logic       id_use_rs, id_use_rt, exe_we, exe_load, mem_we, exe_md, exe_clr;
  logic       o_stall, o_flush, o_bub_exe, o_hold, o_bub_mem, o_busy;
  logic [1:0] o_fwd_a, o_fwd_b;

  int errors = 0;
  int checks = 0;

  // Model state: how many cycles the current md op has spent in EXE (0 = none)
  int         md_age = 0;
  logic [1:0] m_fwd_a = 2'b00;
  logic [1:0] m_fwd_b = 2'b00;
  logic [9:0] exp_v, obs_v;

  exe_hazard_sched #(.MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst(rst),
    .i_HS_idRs(id_rs), .i_HS_idRt(id_rt),
    .i_HS_idUseRs(id_use_rs), .i_HS_idUseRt(id_use_rt),
    .i_HS_exeRegWe(exe_we), .i_HS_exeLoad(exe_load), .i_HS_exeWRA(exe_wra),
    .i_HS_memRegWe(mem_we), .i_HS_memWRA(mem_wra),
    .i_HS_exeMd(exe_md), .i_HS_exeClr(exe_clr),
    .o_HS_stall(o_stall), .o_HS_flushID(o_flush), .o_HS_bubbleEXE(o_bub_exe),
    .o_HS_holdEXE(o_hold), .o_HS_bubbleMEM(o_bub_mem),
    .o_HS_fwdA(o_fwd_a), .o_HS_fwdB(o_fwd_b), .o_HS_mdBusy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic bit hits(input bit use_s, input logic [4:0] s, input bit we, input logic [4:0] wra);
    return use_s && (s != 5'd0) && we && (s == wra);
  endfunction

  function automatic logic [1:0] src_sel(input bit use_s, input logic [4:0] s);
    if (hits(use_s, s, exe_we, exe_wra)) return 2'b01;
    if (hits(use_s, s, mem_we, mem_wra)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit data_hazard();
`ifdef EXE_HS_FWD_EN
    return exe_load && (hits(id_use_rs, id_rs, exe_we, exe_wra) || hits(id_use_rt, id_rt, exe_we, exe_wra));
`else
    return (src_sel(id_use_rs, id_rs) != 2'b00) || (src_sel(id_use_rt, id_rt) != 2'b00);
`endif
  endfunction

  // Expected {stall, flushID, bubbleEXE, holdEXE, bubbleMEM, mdBusy, fwdA, fwdB}
  function automatic logic [9:0] model_out();
    logic [5:0] ctl;
    if (rst) return 10'd0;
    if (md_age > 0)       ctl = 6'b100111;
    else if (exe_clr)     ctl = 6'b011000;
    else if (exe_md)      ctl = 6'b100111;
    else if (data_hazard()) ctl = 6'b101000;
    else                  ctl = 6'b000000;
    return {ctl, m_fwd_a, m_fwd_b};
  endfunction

  // Advance the model across one clock edge using the current inputs
  task automatic model_step();
    if (rst) begin
      md_age  = 0;
      m_fwd_a = 2'b00;
      m_fwd_b = 2'b00;
    end else if (md_age > 0) begin
      md_age = (md_age + 1 >= MD_LAT) ? 0 : md_age + 1;
    end else if (exe_clr || (!exe_md && data_hazard())) begin
      m_fwd_a = 2'b00;
      m_fwd_b = 2'b00;
    end else if (exe_md) begin
      md_age = 1;
    end else begin
`ifdef EXE_HS_FWD_EN
      m_fwd_a = src_sel(id_use_rs, id_rs);
      m_fwd_b = src_sel(id_use_rt, id_rt);
`endif
    end
  endtask

  // Sample the DUT mid-cycle, record the model's expectation, then cross the edge
  task automatic tick();
    @(negedge clk);
    obs_v = {o_stall, o_flush, o_bub_exe, o_hold, o_bub_mem, o_busy, o_fwd_a, o_fwd_b};
    exp_v = model_out();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    exe_we = 1'b0; exe_load = 1'b0; exe_wra = 5'd0; mem_we = 1'b0; mem_wra = 5'd0;
    exe_md = 1'b0; exe_clr = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1; exe_md = 1'b1; exe_clr = 1'b1; exe_we = 1'b1; exe_wra = 5'd3;
    id_use_rs = 1'b1; id_rs = 5'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_v !== 10'd0) begin errors++; $display("[TB] FAIL reset_outputs got=%b want=%b", obs_v, 10'd0); end
    end
    set_idle();
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL reset_release got=%b want=%b", obs_v, exp_v); end
  endtask

  task automatic test_forward_exe();
    set_idle();
    exe_we = 1'b1; exe_wra = 5'd5; id_use_rs = 1'b1; id_rs = 5'd5;
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL fwd_exe_issue got=%b want=%b", obs_v, exp_v); end
    set_idle();
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL fwd_exe_sel got=%b want=%b", obs_v, exp_v); end
  endtask

  task automatic test_forward_mem();
    set_idle();
    mem_we = 1'b1; mem_wra = 5'd5; id_use_rt = 1'b1; id_rt = 5'd5;
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL fwd_mem_issue got=%b want=%b", obs_v, exp_v); end
    set_idle();
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL fwd_mem_sel got=%b want=%b", obs_v, exp_v); end
  endtask

  task automatic test_r0();
    set_idle();
    exe_we = 1'b1; exe_wra = 5'd0; id_use_rs = 1'b1; id_rs = 5'd0;
    mem_we = 1'b1; mem_wra = 5'd0; id_use_rt = 1'b1; id_rt = 5'd0;
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL r0_issue got=%b want=%b", obs_v, exp_v); end
    set_idle();
    tick();
    checks++;
    if (obs_v[3:0] !== 4'b0000 || obs_v !== exp_v) begin errors++; $display("[TB] FAIL r0_fwd got=%b want=%b", obs_v, exp_v); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    int want;
    set_idle();
    for (int c = 0; c < 4; c++) begin
      set_idle();
      if (c < 3) begin id_use_rt = 1'b1; id_rt = 5'd7; end
      if (c == 0) begin exe_we = 1'b1; exe_load = 1'b1; exe_wra = 5'd7; end
      if (c == 1) begin mem_we = 1'b1; mem_wra = 5'd7; end
      tick();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL load_use_c%0d got=%b want=%b", c, obs_v, exp_v); end
      if (obs_v[9]) stalls++;
    end
`ifdef EXE_HS_FWD_EN
    want = 1;
`else
    want = 2;
`endif
    checks++;
    if (stalls != want) begin errors++; $display("[TB] FAIL load_use_stall_cycles got=%0d want=%0d", stalls, want); end
  endtask

  task automatic test_branch();
    set_idle();
    exe_we = 1'b1; exe_load = 1'b1; exe_wra = 5'd9; id_use_rs = 1'b1; id_rs = 5'd9; exe_clr = 1'b1;
    tick();
    checks++;
    if (obs_v[9:4] !== 6'b011000 || obs_v !== exp_v) begin errors++; $display("[TB] FAIL branch_over_load got=%b want=%b", obs_v, exp_v); end
    set_idle();
    tick();
    checks++;
    if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL branch_after got=%b want=%b", obs_v, exp_v); end
  endtask

  task automatic test_md();
    int busy = 0;
    int hold = 0;
    for (int i = 0; i < MD_LAT + 4; i++) begin
      set_idle();
      exe_md  = (i < MD_LAT);
      exe_clr = (i == 5) || (i == 20);
      tick();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL md_cycle%0d got=%b want=%b", i, obs_v, exp_v); end
      if (obs_v[4]) busy++;
      if (obs_v[6]) hold++;
    end
    checks++;
    if (busy != MD_LAT || hold != MD_LAT) begin errors++; $display("[TB] FAIL md_occupancy busy=%0d hold=%0d want=%0d", busy, hold, MD_LAT); end
  endtask

  task automatic test_back_to_back();
    int busy = 0;
    for (int i = 0; i < 2 * MD_LAT + 3; i++) begin
      set_idle();
      exe_md = (i < 2 * MD_LAT);
      tick();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL b2b_cycle%0d got=%b want=%b", i, obs_v, exp_v); end
      if (obs_v[4]) busy++;
    end
    checks++;
    if (busy != 2 * MD_LAT) begin errors++; $display("[TB] FAIL b2b_busy got=%0d want=%0d", busy, 2 * MD_LAT); end
  endtask

  task automatic test_md_reset();
    set_idle();
    exe_md = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL mdrst_cycle%0d got=%b want=%b", i, obs_v, exp_v); end
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs_v !== 10'd0) begin errors++; $display("[TB] FAIL mdrst_in_reset got=%b want=%b", obs_v, 10'd0); end
    set_idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_v !== 10'd0) begin errors++; $display("[TB] FAIL mdrst_run%0d got=%b want=%b", i, obs_v, 10'd0); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      id_rs     = 5'($urandom_range(0, 3));
      id_rt     = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);
      id_use_rt = 1'($urandom);
      exe_we    = 1'($urandom);
      exe_load  = 1'($urandom);
      exe_wra   = 5'($urandom_range(0, 3));
      mem_we    = 1'($urandom);
      mem_wra   = 5'($urandom_range(0, 3));
      exe_md    = ($urandom_range(0, 15) == 0);
      exe_clr   = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (obs_v !== exp_v) begin errors++; $display("[TB] FAIL random_cycle%0d got=%b want=%b", i, obs_v, exp_v); end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_forward_exe();
    test_forward_mem();
    test_r0();
    test_load_use();
    test_branch();
    test_md();
    test_back_to_back();
    test_md_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
